// File: rtl/cpu_pkg.sv
// Shared types and constants for the WISC memory-side control logic.
//   stateT : miss arbiter sequencing states
//   ownerT : which cache owns the block fill in progress
//   BLK_WORDS / BLK_OFFSET_BITS / CNT_W : cache block geometry
//   wordOffset() : byte offset of a word index within a block
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } stateT;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } ownerT;

  localparam int BLK_WORDS       = 8;
  localparam int BLK_OFFSET_BITS = 4;
  localparam int CNT_W           = 3;

  // Words are 2 bytes, so the byte offset is the word index shifted by one.
  function automatic logic [BLK_OFFSET_BITS-1:0] wordOffset(input logic [CNT_W-1:0] idx);
    return {idx, 1'b0};
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Word counter for one block transfer (request side or return side).
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : force count to 0 (has priority over inc)
//   inc        : advance count by one, wrapping 7 -> 0
//   count      : current word index
//   termCount  : high while count is the last word of the block
module fill_counter
  import cpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             termCount
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign termCount = (count == CNT_W'(BLK_WORDS - 1));

endmodule

// File: rtl/miss_arbiter.sv
// Main-memory arbiter for the WISC I-cache, D-cache and write-through store path.
// Write-through stores go straight to memory from IDLE; cache misses stream an
// 8-word block into the owning cache and finish with a one-cycle tag write.
//   clk, rst_n                     : clock, synchronous active-low reset
//   i_miss/i_miss_addr             : I-cache miss request (level) and byte address
//   d_miss/d_miss_addr             : D-cache miss request (level) and byte address
//   d_wr/d_wr_addr/d_wr_data       : write-through store request
//   mem_en/mem_wr/mem_addr/mem_wdata : memory request port
//   mem_data_valid/mem_rdata       : memory read return
//   fill_we_i/fill_we_d/fill_addr/fill_data : cache data-array write port
//   tag_we_i/tag_we_d              : tag/valid write pulse at end of fill
//   stall_if/stall_mem             : pipeline freeze
//
// state | meaning
// IDLE  | no fill in progress; stores served here, misses accepted here
// ISSUE | sending the 8 read requests of a block, collecting early returns
// DRAIN | all requests sent, waiting for the remaining returns
// DONE  | all 8 words written; pulse tag write for the owning cache
module miss_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [ADDR_W-1:0] fill_addr,
  output logic [DATA_W-1:0] fill_data,
  output logic              tag_we_i,
  output logic              tag_we_d,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'((1 << BLK_OFFSET_BITS) - 1);

  stateT             state, nextState;
  ownerT             owner, nextOwner;
  logic [ADDR_W-1:0] blkBase, nextBase;

  logic             cntClr;
  logic             icntInc, rcntInc;
  logic [CNT_W-1:0] icnt, rcnt;
  logic             icntTc, rcntTc;

  fill_counter u_icnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cntClr),
    .inc       (icntInc),
    .count     (icnt),
    .termCount (icntTc)
  );

  fill_counter u_rcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cntClr),
    .inc       (rcntInc),
    .count     (rcnt),
    .termCount (rcntTc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= OWN_I;
      blkBase <= '0;
    end else begin
      state   <= nextState;
      owner   <= nextOwner;
      blkBase <= nextBase;
    end
  end

  always_comb begin
    nextState = state;
    nextOwner = owner;
    nextBase  = blkBase;
    cntClr    = 1'b0;
    icntInc   = 1'b0;
    rcntInc   = 1'b0;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    fill_we_i = 1'b0;
    fill_we_d = 1'b0;
    fill_addr = '0;
    fill_data = '0;
    tag_we_i  = 1'b0;
    tag_we_d  = 1'b0;
    stall_mem = d_miss | (d_wr & (state != IDLE));
    stall_if  = i_miss | stall_mem;

    case (state)
      IDLE: begin
        // Counters are held clear here so a new fill always starts at word 0.
        cntClr = 1'b1;
        if (d_wr) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
        end else if (d_miss) begin
          nextOwner = OWN_D;
          nextBase  = d_miss_addr & BLK_MASK;
          nextState = ISSUE;
        end else if (i_miss) begin
          nextOwner = OWN_I;
          nextBase  = i_miss_addr & BLK_MASK;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = blkBase + ADDR_W'(wordOffset(icnt));
        icntInc  = 1'b1;
        if (icntTc) nextState = DRAIN;
      end
      DRAIN: begin
      end
      DONE: begin
        tag_we_i  = (owner == OWN_I);
        tag_we_d  = (owner == OWN_D);
        fill_addr = blkBase;
        cntClr    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Returns can overlap the issue phase, so they are handled for both
    // ISSUE and DRAIN; the last return wins over the ISSUE->DRAIN move.
    if ((state == ISSUE || state == DRAIN) && mem_data_valid) begin
      fill_we_i = (owner == OWN_I);
      fill_we_d = (owner == OWN_D);
      fill_addr = blkBase + ADDR_W'(wordOffset(rcnt));
      fill_data = mem_rdata;
      rcntInc   = 1'b1;
      if (rcntTc) nextState = DONE;
    end

    // Keep the memory and caches quiet for the whole reset cycle.
    if (!rst_n) begin
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      fill_we_i = 1'b0;
      fill_we_d = 1'b0;
      fill_addr = '0;
      fill_data = '0;
      tag_we_i  = 1'b0;
      tag_we_d  = 1'b0;
      stall_mem = 1'b0;
      stall_if  = 1'b0;
    end
  end

endmodule

// File: tb/tb_miss_arbiter.sv
// Bench for miss_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-timing model of the arbiter
// and a 4-cycle-latency memory model.
module tb_miss_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_rdata;
  logic        fill_we_i, fill_we_d;
  logic [15:0] fill_addr, fill_data;
  logic        tag_we_i, tag_we_d;
  logic        stall_if, stall_mem;

  always #5 clk = ~clk;

  miss_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .d_wr           (d_wr),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_data_valid (mem_data_valid),
    .mem_rdata      (mem_rdata),
    .fill_we_i      (fill_we_i),
    .fill_we_d      (fill_we_d),
    .fill_addr      (fill_addr),
    .fill_data      (fill_data),
    .tag_we_i       (tag_we_i),
    .tag_we_d       (tag_we_d),
    .stall_if       (stall_if),
    .stall_mem      (stall_mem)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Requesters
  bit          rstN, iReq, dReq, wReq;
  logic [15:0] iAddr, dAddr, wAddr, wData;

  // Timing model: k = cycles since a miss was accepted (-1 when idle)
  int          k = -1;
  bit          ownD;
  logic [15:0] base;
  int          nFill;

  // Memory model: read issued in cycle c returns in cycle c+4
  bit          pipeV[4];
  logic [15:0] pipeD[4];

  // Observation counters for directed scenarios
  int          fillICount, fillDCount, tagICount, tagDCount;
  logic [15:0] watchAddr;
  int          watchCyc, storeCyc, tStart;

  task automatic checkInt(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clearObs();
    fillICount = 0; fillDCount = 0; tagICount = 0; tagDCount = 0;
    watchCyc = -1; storeCyc = -1; tStart = cyc;
  endtask

  task automatic step();
    logic        expEn, expWr, expFwI, expFwD, expTagI, expTagD, expSi, expSm, busy;
    logic [15:0] expAddr, expWdata, expFAddr, expFData;
    logic [33:0] obsMem, expMem, mskMem, obsFill, expFill, mskFill;
    logic [3:0]  obsCtl, expCtl;
    int          nextK;
    bit          dropI, dropD, dropW;

    rst_n          = rstN;
    i_miss         = iReq;  i_miss_addr = iAddr;
    d_miss         = dReq;  d_miss_addr = dAddr;
    d_wr           = wReq;  d_wr_addr   = wAddr;  d_wr_data = wData;
    mem_data_valid = pipeV[3];
    mem_rdata      = pipeV[3] ? pipeD[3] : 16'($urandom);
    #1;

    expEn = 0; expWr = 0; expAddr = 0; expWdata = 0;
    expFwI = 0; expFwD = 0; expFAddr = 0; expFData = 0;
    expTagI = 0; expTagD = 0; expSi = 0; expSm = 0;
    mskMem = '1; mskFill = '1;
    nextK = k; dropI = 0; dropD = 0; dropW = 0;
    busy = (k >= 1);

    if (!rstN) begin
      nextK = -1;
    end else begin
      expSm = dReq | (wReq & busy);
      expSi = iReq | expSm;
      if (!busy) begin
        if (wReq) begin
          expEn = 1; expWr = 1; expAddr = wAddr; expWdata = wData; dropW = 1;
        end else if (dReq || iReq) begin
          ownD  = dReq;
          base  = (dReq ? dAddr : iAddr) & 16'hFFF0;
          nFill = 0;
          nextK = 1;
        end
      end else begin
        if (k <= 8) begin
          expEn   = 1;
          expAddr = base + 16'(2 * (k - 1));
          mskMem  = {2'b11, 16'hFFFF, 16'h0000};
        end else begin
          mskMem  = {2'b11, 32'h0};
        end
        mskFill = {2'b11, 32'h0};
        if (k <= 12 && pipeV[3]) begin
          expFwI   = !ownD;
          expFwD   = ownD;
          expFAddr = base + 16'(2 * nFill);
          expFData = pipeD[3];
          mskFill  = '1;
          nFill++;
        end
        if (k == 13) begin
          expTagI  = !ownD;
          expTagD  = ownD;
          expFAddr = base;
          mskFill  = {2'b11, 16'hFFFF, 16'h0000};
          nextK    = -1;
          dropD    = ownD;
          dropI    = !ownD;
        end else begin
          nextK = k + 1;
        end
      end
    end

    obsMem  = {mem_en, mem_wr, mem_addr, mem_wdata};
    expMem  = {expEn, expWr, expAddr, expWdata};
    obsFill = {fill_we_i, fill_we_d, fill_addr, fill_data};
    expFill = {expFwI, expFwD, expFAddr, expFData};
    obsCtl  = {tag_we_i, tag_we_d, stall_if, stall_mem};
    expCtl  = {expTagI, expTagD, expSi, expSm};

    checks++;
    assert ((obsMem & mskMem) === (expMem & mskMem)) else begin
      failures++;
      $error("FAIL mem_bus cyc=%0d observed=%h expected=%h", cyc, obsMem & mskMem, expMem & mskMem);
    end
    checks++;
    assert ((obsFill & mskFill) === (expFill & mskFill)) else begin
      failures++;
      $error("FAIL fill_port cyc=%0d observed=%h expected=%h", cyc, obsFill & mskFill, expFill & mskFill);
    end
    checks++;
    assert (obsCtl === expCtl) else begin
      failures++;
      $error("FAIL tag_stall cyc=%0d observed=%b expected=%b", cyc, obsCtl, expCtl);
    end

    if (fill_we_i) fillICount++;
    if (fill_we_d) fillDCount++;
    if (tag_we_i)  tagICount++;
    if (tag_we_d)  tagDCount++;
    if (mem_en && !mem_wr && mem_addr == watchAddr && watchCyc < 0) watchCyc = cyc - tStart;
    if (mem_en && mem_wr && storeCyc < 0) storeCyc = cyc - tStart;

    for (int s = 3; s > 0; s--) begin
      pipeV[s] = pipeV[s-1];
      pipeD[s] = pipeD[s-1];
    end
    pipeV[0] = mem_en && !mem_wr;
    pipeD[0] = 16'($urandom);

    @(posedge clk);
    #1;
    k = nextK;
    if (dropI) iReq = 0;
    if (dropD) dReq = 0;
    if (dropW) wReq = 0;
    cyc++;
  endtask

  initial begin
    for (int s = 0; s < 4; s++) begin
      pipeV[s] = 0;
      pipeD[s] = '0;
    end
    rstN = 0; iReq = 0; dReq = 0; wReq = 0;
    iAddr = '0; dAddr = '0; wAddr = '0; wData = '0;
    watchAddr = '0;
    clearObs();

    // Reset, then quiet idle
    step(); step();
    rstN = 1;
    step(); step();

    // Lone I miss at 0x1236
    clearObs();
    iReq = 1; iAddr = 16'h1236; watchAddr = 16'h1230;
    repeat (16) step();
    checkInt("lone_i_fill_count", fillICount, 8);
    checkInt("lone_i_tag_count", tagICount, 1);
    checkInt("lone_i_first_issue", watchCyc, 1);

    // Same-cycle I and D misses: D first, I issue starts at t+15
    clearObs();
    iReq = 1; iAddr = 16'h0040; dReq = 1; dAddr = 16'h8008; watchAddr = 16'h0040;
    repeat (32) step();
    checkInt("both_i_issue_start", watchCyc, 15);
    checkInt("both_d_fill_count", fillDCount, 8);
    checkInt("both_i_fill_count", fillICount, 8);

    // Store arriving during a D fill waits for IDLE
    clearObs();
    dReq = 1; dAddr = 16'h3010;
    repeat (3) step();
    wReq = 1; wAddr = 16'h2002; wData = 16'hBEEF;
    repeat (13) step();
    checkInt("store_held_cycle", storeCyc, 14);

    // Store and D miss together in IDLE: store first, fill next cycle
    clearObs();
    wReq = 1; wAddr = 16'h4444; wData = 16'h1234;
    dReq = 1; dAddr = 16'h5006; watchAddr = 16'h5000;
    repeat (16) step();
    checkInt("store_first_cycle", storeCyc, 0);
    checkInt("miss_after_store_issue", watchCyc, 2);

    // Reset at t+6 of an I fill; late returns must be dropped
    clearObs();
    iReq = 1; iAddr = 16'h0A00;
    repeat (6) step();
    rstN = 0;
    step();
    rstN = 1; iReq = 0;
    fillICount = 0;
    repeat (6) step();
    checkInt("reset_late_fills", fillICount, 0);
    clearObs();
    iReq = 1; iAddr = 16'h0A02;
    repeat (16) step();
    checkInt("post_reset_fill_count", fillICount, 8);

    // Top-of-memory block: no carry out of the block
    clearObs();
    dReq = 1; dAddr = 16'hFFF2; watchAddr = 16'hFFFE;
    repeat (16) step();
    checkInt("wrap_last_issue", watchCyc, 8);
    checkInt("wrap_fill_count", fillDCount, 8);

    // Random traffic
    repeat (3000) begin
      if (!iReq && $urandom_range(0, 7) == 0) begin iReq = 1; iAddr = 16'($urandom); end
      if (!dReq && $urandom_range(0, 7) == 0) begin dReq = 1; dAddr = 16'($urandom); end
      if (!wReq && $urandom_range(0, 5) == 0) begin
        wReq = 1; wAddr = 16'($urandom); wData = 16'($urandom);
      end
      step();
    end
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
